segment_update_master: RTL and testbench
========================================

SEGMENT_UPDATE_MASTER -- requirements
Module: segment_update_master

Interface
REQ-001 Parameter ID_VALUE, default 64: value the peripheral's identification register (word address 0) SHALL return.
REQ-002 Parameter SKIP_UNCHANGED, default 1: when 1, register writes whose data equals the last value written SHALL be suppressed.
REQ-003 csi_clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rsi_reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_value  in  16  four hex nibbles; bits[15:12] are the leftmost digit (address 1), bits[3:0] the rightmost (address 4).
REQ-008 cmd_dots  in  4  decimal points; bit3 maps to address 5 and bit0 to address 8.
REQ-009 cmd_light  in  3  brightness level, written identically to addresses 11-14.
REQ-010 cmd_blank  in  1  enables leading-zero blanking.
REQ-011 done  out  1  one-cycle pulse when a command completes.
REQ-012 id_ok / id_err  out  1 each  result of the identification check.
REQ-013 avm_m0_address  out  5  word address; avm_m0_write / avm_m0_read  out  1; avm_m0_writedata  out  32; avm_m0_readdata  in  32; avm_m0_waitrequest  in  1.

Function
REQ-014 The FSM SHALL have the states ID_RD, ID_ERR, IDLE, WRITE and DONE; it SHALL leave reset in ID_RD.
REQ-015 ID_RD SHALL assert read with address 0 and hold both until waitrequest=0, then sample readdata in that same cycle.
REQ-016 On that sample, readdata==ID_VALUE SHALL set id_ok=1 and go to IDLE; otherwise it SHALL set id_err=1 and go to ID_ERR.
REQ-017 ID_ERR SHALL be terminal until reset: cmd_ready=0 and no bus activity.
REQ-018 Accept condition is cmd_valid&&cmd_ready; on acceptance all cmd_* inputs SHALL be latched, and the FSM SHALL enter WRITE on the next cycle.
REQ-019 WRITE SHALL step through 13 items in this fixed order: addresses 1,2,3,4 (digit codes), 5,6,7,8 (dots), 11,12,13,14 (light), 9 (enable, data 1).
REQ-020 Digit code = nibble+1 (0->1 ... F->16), zero-extended to 32 bits.
REQ-021 If cmd_blank=1, each zero nibble to the left of the first nonzero nibble SHALL use code 0; address 4 SHALL never be blanked.
REQ-022 For each item, write, address and writedata SHALL be held stable while waitrequest=1; the item completes in the first cycle with waitrequest=0, and the next item starts in the following cycle.
REQ-023 When SKIP_UNCHANGED=1 and the item's shadow entry is valid and equal to the new data, the item SHALL consume one cycle with write=0.
REQ-024 On each completed write, the item's shadow entry SHALL be updated and marked valid.
REQ-025 After item 13 completes, the FSM SHALL enter DONE, pulse done for 1 cycle, and return to IDLE.
REQ-026 With waitrequest=0 throughout, done SHALL be asserted exactly 14 cycles after the acceptance cycle, independent of skipping; each waitrequest stall cycle SHALL add 1 cycle.
REQ-027 read and write SHALL never be asserted together; cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-028 Asserting rsi_reset_n=0 SHALL immediately force: cmd_ready, done, id_ok, id_err, avm_m0_read and avm_m0_write = 0; address and writedata = 0; all shadow entries invalid; state ID_RD.
REQ-029 A reset during any state, including mid-stall, SHALL abandon the operation; after release the identification read SHALL restart.

Structure
REQ-030 The shared package seg_master_pkg SHALL hold the register address constants, the item count (13), the state enum and the default ID value.
REQ-031 The nibble-to-code/blanking logic SHALL be the combinational sub-module seg_char_encoder.

Verification
REQ-032 Release reset with the slave returning 64 and waitrequest=0 -> read asserted at address 0; id_ok=1; cmd_ready=1 on the next cycle.
REQ-033 Slave returns 0 -> id_err=1; cmd_ready stays 0 and no bus cycles occur for 100 cycles despite cmd_valid=1.
REQ-034 cmd_value=0x12AF, dots=0010, light=7, blank=0, no waitrequest -> writes (1,2) (2,3) (3,11) (4,16) (5,0) (6,0) (7,1) (8,0) (11..14,7) (9,1); done at acceptance+14.
REQ-035 The same command repeated with SKIP_UNCHANGED=1 -> zero writes; done still at acceptance+14.
REQ-036 cmd_value=0x0007 with blank=1 -> addresses 1-3 receive data 0 and address 4 receives data 8; with blank=0, addresses 1-3 receive data 1.
REQ-037 waitrequest held high for 3 cycles on the address-3 write -> address/data stable throughout and done at acceptance+17; reset pulsed mid-sequence -> write drops immediately and the ID read repeats.

Source files
------------

// File: rtl/seg_master_pkg.sv
// Shared definitions for the segment display update master.
// Holds register map constants, item sequencing helpers, FSM state type
// and the default identification value expected from the peripheral.
package seg_master_pkg;

   localparam int unsigned ADDR_W           = 5;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned CODE_W           = 5;
   localparam int unsigned NUM_DIGITS       = 4;
   localparam int unsigned NUM_ITEMS        = 13;
   localparam int unsigned ITEM_W           = 4;
   localparam int unsigned ID_VALUE_DEFAULT = 64;

   localparam logic [ADDR_W-1:0] ADDR_ID     = 5'd0;
   localparam logic [ADDR_W-1:0] ADDR_DIGIT0 = 5'd1;
   localparam logic [ADDR_W-1:0] ADDR_DOT0   = 5'd5;
   localparam logic [ADDR_W-1:0] ADDR_ENABLE = 5'd9;
   localparam logic [ADDR_W-1:0] ADDR_LIGHT0 = 5'd11;

   typedef enum logic [2:0] {
      ST_ID_RD,
      ST_ID_ERR,
      ST_IDLE,
      ST_WRITE,
      ST_DONE
   } state_e;

   // codes[0] belongs to the leftmost digit (address 1)
   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] codes_t;

   // Item order: digits 0-3, dots 4-7, light 8-11, enable 12
   function automatic logic [ADDR_W-1:0] item_addr(input logic [ITEM_W-1:0] idx);
      logic [ADDR_W-1:0] a;
      if (idx < 4'd4)       a = ADDR_DIGIT0 + ADDR_W'(idx);
      else if (idx < 4'd8)  a = ADDR_DOT0   + ADDR_W'(idx - 4'd4);
      else if (idx < 4'd12) a = ADDR_LIGHT0 + ADDR_W'(idx - 4'd8);
      else                  a = ADDR_ENABLE;
      return a;
   endfunction

   function automatic logic [CODE_W-1:0] item_data(input logic [ITEM_W-1:0] idx,
                                                   input codes_t         codes,
                                                   input logic [3:0]     dots,
                                                   input logic [2:0]     light);
      logic [CODE_W-1:0] d;
      if (idx < 4'd4)       d = codes[idx[1:0]];
      else if (idx < 4'd8)  d = CODE_W'(dots[2'd3 - idx[1:0]]);
      else if (idx < 4'd12) d = CODE_W'(light);
      else                  d = CODE_W'(1);
      return d;
   endfunction

endpackage

// File: rtl/seg_char_encoder.sv
// Nibble-to-digit-code encoder with optional leading-zero blanking.
// Ports: value_i  - four hex nibbles, [15:12] leftmost
//        blank_i  - blank zero nibbles left of the first nonzero one
//        codes_c_o - per-digit code (nibble+1, or 0 when blanked)
module seg_char_encoder
   import seg_master_pkg::*;
(
   input  logic [15:0] value_i,
   input  logic        blank_i,
   output codes_t      codes_c_o
);

   logic       lead;
   logic [3:0] nib;

   // Scan left to right; the rightmost digit is always shown
   always_comb begin
      lead      = blank_i;
      nib       = '0;
      codes_c_o = '0;
      for (int i = 0; i < 4; i++) begin
         nib = value_i[15-4*i -: 4];
         if (lead && (nib == 4'd0) && (i != 3)) begin
            codes_c_o[i] = '0;
         end else begin
            codes_c_o[i] = CODE_W'(nib) + CODE_W'(1);
            lead         = 1'b0;
         end
      end
   end

endmodule

// File: rtl/segment_update_master.sv
// Avalon-MM master that checks a display peripheral's ID and then pushes
// digit codes, decimal points, brightness and enable on each command.
// Ports: csi_clk/rsi_reset_n - clock, async active-low reset
//        cmd_*              - command handshake and payload, done pulse
//        id_ok/id_err       - identification check result
//        avm_m0_*           - Avalon-MM master port
module segment_update_master
   import seg_master_pkg::*;
#(
   parameter int unsigned ID_VALUE       = ID_VALUE_DEFAULT,
   parameter bit          SKIP_UNCHANGED = 1'b1
) (
   input  logic              csi_clk,
   input  logic              rsi_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [15:0]       cmd_value,
   input  logic [3:0]        cmd_dots,
   input  logic [2:0]        cmd_light,
   input  logic              cmd_blank,
   output logic              done,
   output logic              id_ok,
   output logic              id_err,
   output logic [ADDR_W-1:0] avm_m0_address,
   output logic              avm_m0_write,
   output logic              avm_m0_read,
   output logic [DATA_W-1:0] avm_m0_writedata,
   input  logic [DATA_W-1:0] avm_m0_readdata,
   input  logic              avm_m0_waitrequest
);

   state_e                             state_q, state_d;
   logic [ITEM_W-1:0]                  item_q, item_d;
   logic [15:0]                        value_q, value_d;
   logic [3:0]                         dots_q, dots_d;
   logic [2:0]                         light_q, light_d;
   logic                               blank_q, blank_d;
   logic [NUM_ITEMS-1:0][CODE_W-1:0]   shadow_q, shadow_d;
   logic [NUM_ITEMS-1:0]               vld_q, vld_d;
   logic                               ready_q, ready_d;
   logic                               done_q, done_d;
   logic                               ok_q, ok_d;
   logic                               err_q, err_d;
   logic                               read_q, read_d;
   logic                               write_q, write_d;
   logic [ADDR_W-1:0]                  addr_q, addr_d;
   logic [DATA_W-1:0]                  wdata_q, wdata_d;

   logic              accept;
   codes_t            codes;
   logic [CODE_W-1:0] item_val;

   // Command capture
   always_comb begin
      accept  = cmd_valid && ready_q;
      value_d = accept ? cmd_value : value_q;
      dots_d  = accept ? cmd_dots  : dots_q;
      light_d = accept ? cmd_light : light_q;
      blank_d = accept ? cmd_blank : blank_q;
   end

   // Encode from the next-cycle command so the first item is ready at entry to WRITE
   seg_char_encoder u_enc (
      .value_i   (value_d),
      .blank_i   (blank_d),
      .codes_c_o (codes)
   );

   // Next state and registered bus outputs
   always_comb begin
      state_d  = state_q;
      item_d   = item_q;
      shadow_d = shadow_q;
      vld_d    = vld_q;
      ok_d     = ok_q;
      err_d    = err_q;
      read_d   = 1'b0;
      write_d  = 1'b0;
      addr_d   = '0;
      wdata_d  = '0;
      item_val = '0;

      unique case (state_q)
         ST_ID_RD: begin
            if (read_q && !avm_m0_waitrequest) begin
               if (avm_m0_readdata == DATA_W'(ID_VALUE)) begin
                  ok_d    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ID_ERR;
               end
            end
         end
         ST_ID_ERR: state_d = ST_ID_ERR;
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WRITE;
               item_d  = '0;
            end
         end
         ST_WRITE: begin
            // A skipped item (write_q=0) completes unconditionally
            if (!write_q || !avm_m0_waitrequest) begin
               if (write_q) begin
                  shadow_d[item_q] = wdata_q[CODE_W-1:0];
                  vld_d[item_q]    = 1'b1;
               end
               if (item_q == ITEM_W'(NUM_ITEMS - 1)) state_d = ST_DONE;
               else                                   item_d  = item_q + ITEM_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_ID_RD;
      endcase

      if (state_d == ST_ID_RD) begin
         read_d = 1'b1;
         addr_d = ADDR_ID;
      end
      if (state_d == ST_WRITE) begin
         item_val = item_data(item_d, codes, dots_d, light_d);
         addr_d   = item_addr(item_d);
         wdata_d  = DATA_W'(item_val);
         write_d  = !(SKIP_UNCHANGED && vld_d[item_d] && (shadow_d[item_d] == item_val));
      end
      ready_d = (state_d == ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state_q  <= ST_ID_RD;
         item_q   <= '0;
         value_q  <= '0;
         dots_q   <= '0;
         light_q  <= '0;
         blank_q  <= 1'b0;
         shadow_q <= '0;
         vld_q    <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         item_q   <= item_d;
         value_q  <= value_d;
         dots_q   <= dots_d;
         light_q  <= light_d;
         blank_q  <= blank_d;
         shadow_q <= shadow_d;
         vld_q    <= vld_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         read_q   <= read_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign cmd_ready        = ready_q;
   assign done             = done_q;
   assign id_ok            = ok_q;
   assign id_err           = err_q;
   assign avm_m0_read      = read_q;
   assign avm_m0_write     = write_q;
   assign avm_m0_address   = addr_q;
   assign avm_m0_writedata = wdata_q;

endmodule

// File: tb/tb_segment_update_master.sv
// Directed bench for segment_update_master: ID check, write sequences,
// skipping, blanking, stall latency and mid-sequence reset.
module tb_segment_update_master;

   logic        csi_clk = 1'b0;
   logic        rsi_reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_value = '0;
   logic [3:0]  cmd_dots = '0;
   logic [2:0]  cmd_light = '0;
   logic        cmd_blank = 1'b0;
   logic        done, id_ok, id_err;
   logic [4:0]  avm_m0_address;
   logic        avm_m0_write, avm_m0_read;
   logic [31:0] avm_m0_writedata;
   logic [31:0] avm_m0_readdata = 32'd64;
   logic        avm_m0_waitrequest = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int done_cyc = 0;
   bit done_seen = 0;
   bit bus_watch = 0;
   int bus_hits = 0;
   int ready_hits = 0;
   int both_hits = 0;
   bit stall_arm = 0;
   int stall_cnt = 0;
   int wlog[$];

   segment_update_master dut (
      .csi_clk            (csi_clk),
      .rsi_reset_n        (rsi_reset_n),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_value          (cmd_value),
      .cmd_dots           (cmd_dots),
      .cmd_light          (cmd_light),
      .cmd_blank          (cmd_blank),
      .done               (done),
      .id_ok              (id_ok),
      .id_err             (id_err),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_write       (avm_m0_write),
      .avm_m0_read        (avm_m0_read),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_readdata    (avm_m0_readdata),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   initial forever #5 csi_clk = ~csi_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: completed writes, accept/done cycles, illegal activity
   always @(posedge csi_clk) begin
      if (rsi_reset_n) begin
         if (avm_m0_write && !avm_m0_waitrequest)
            wlog.push_back(int'(avm_m0_address) * 256 + int'(avm_m0_writedata));
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (done) begin
            done_cyc  = cyc;
            done_seen = 1;
         end
         if (bus_watch && (avm_m0_read || avm_m0_write)) bus_hits++;
         if (bus_watch && cmd_ready) ready_hits++;
         if (avm_m0_read && avm_m0_write) both_hits++;
      end
      cyc++;
   end

   // Slave stall: hold waitrequest for 3 cycles on the first armed address-3 write
   always @(negedge csi_clk) begin
      if (stall_cnt == 0 && stall_arm && avm_m0_write && avm_m0_address == 5'd3) begin
         avm_m0_waitrequest = 1'b1;
         stall_cnt = 3;
         stall_arm = 0;
      end else if (stall_cnt != 0) begin
         chk("stall_addr", 32'(avm_m0_address), 32'd3);
         chk("stall_data", avm_m0_writedata, 32'd6);
         chk("stall_wr", 32'(avm_m0_write), 32'd1);
         stall_cnt--;
         if (stall_cnt == 0) avm_m0_waitrequest = 1'b0;
      end
   end

   task automatic do_reset(input string tag);
      rsi_reset_n = 1'b0;
      cmd_valid   = 1'b0;
      repeat (3) @(negedge csi_clk);
      chk({tag, "_rd"},    32'(avm_m0_read), 32'd0);
      chk({tag, "_wr"},    32'(avm_m0_write), 32'd0);
      chk({tag, "_rdy"},   32'(cmd_ready), 32'd0);
      chk({tag, "_okerr"}, 32'({id_ok, id_err, done}), 32'd0);
      chk({tag, "_addr"},  32'(avm_m0_address), 32'd0);
      rsi_reset_n = 1'b1;
   endtask

   task automatic wait_id(input string tag, input bit exp_ok);
      int n = 0;
      while (!avm_m0_read && n < 20) begin @(negedge csi_clk); n++; end
      chk({tag, "_read"}, 32'(avm_m0_read), 32'd1);
      chk({tag, "_raddr"}, 32'(avm_m0_address), 32'd0);
      n = 0;
      while (!(id_ok || id_err) && n < 20) begin @(negedge csi_clk); n++; end
      chk({tag, "_ok"},  32'(id_ok), 32'(exp_ok));
      chk({tag, "_err"}, 32'(id_err), 32'(!exp_ok));
      chk({tag, "_rdy"}, 32'(cmd_ready), 32'(exp_ok));
   endtask

   task automatic run_cmd(input string tag, input logic [15:0] v, input logic [3:0] d,
                          input logic [2:0] l, input logic b, input int lat, input int exp_q[$]);
      int n = 0;
      while (!cmd_ready && n < 50) begin @(negedge csi_clk); n++; end
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      wlog.delete();
      done_seen = 0;
      cmd_value = v; cmd_dots = d; cmd_light = l; cmd_blank = b;
      cmd_valid = 1'b1;
      @(negedge csi_clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!done_seen && n < 60) begin @(negedge csi_clk); n++; end
      chk({tag, "_lat"}, done_seen ? 32'(done_cyc - acc_cyc) : 32'hFFFF_FFFF, 32'(lat));
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_nwr"}, 32'(wlog.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int eq[$];
      @(negedge csi_clk);
      do_reset("rst0");
      wait_id("id0", 1'b1);

      eq = '{32'h102, 32'h203, 32'h30B, 32'h410, 32'h500, 32'h600, 32'h701, 32'h800,
             32'hB07, 32'hC07, 32'hD07, 32'hE07, 32'h901};
      run_cmd("c12af", 16'h12AF, 4'b0010, 3'd7, 1'b0, 14, eq);

      eq.delete();
      run_cmd("repeat", 16'h12AF, 4'b0010, 3'd7, 1'b0, 14, eq);

      eq = '{32'h100, 32'h200, 32'h300, 32'h408};
      run_cmd("blank1", 16'h0007, 4'b0010, 3'd7, 1'b1, 14, eq);

      eq = '{32'h101, 32'h201, 32'h301};
      run_cmd("blank0", 16'h0007, 4'b0010, 3'd7, 1'b0, 14, eq);

      stall_arm = 1;
      eq = '{32'h306};
      run_cmd("stall", 16'h0057, 4'b0010, 3'd7, 1'b0, 17, eq);
      chk("stall_used", 32'(stall_arm), 32'd0);

      // Reset in the middle of a write sequence
      cmd_value = 16'h1234; cmd_dots = 4'b0000; cmd_light = 3'd3; cmd_blank = 1'b0;
      cmd_valid = 1'b1;
      @(negedge csi_clk);
      cmd_valid = 1'b0;
      chk("mid_wr_before", 32'(avm_m0_write), 32'd1);
      rsi_reset_n = 1'b0;
      #1;
      chk("mid_wr_drop", 32'(avm_m0_write), 32'd0);
      chk("mid_addr", 32'(avm_m0_address), 32'd0);
      chk("mid_rdy", 32'(cmd_ready), 32'd0);
      @(negedge csi_clk);
      @(negedge csi_clk);
      rsi_reset_n = 1'b1;
      wait_id("id1", 1'b1);

      eq = '{32'h102, 32'h203, 32'h304, 32'h405, 32'h500, 32'h600, 32'h700, 32'h800,
             32'hB03, 32'hC03, 32'hD03, 32'hE03, 32'h901};
      run_cmd("post_rst", 16'h1234, 4'b0000, 3'd3, 1'b0, 14, eq);

      // Wrong ID: terminal error state
      avm_m0_readdata = 32'd0;
      do_reset("rst1");
      wait_id("iderr", 1'b0);
      bus_watch = 1;
      cmd_valid = 1'b1;
      repeat (100) @(negedge csi_clk);
      cmd_valid = 1'b0;
      bus_watch = 0;
      chk("err_bus", 32'(bus_hits), 32'd0);
      chk("err_ready", 32'(ready_hits), 32'd0);
      chk("err_sticky", 32'(id_err), 32'd1);
      chk("rd_wr_excl", 32'(both_hits), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
